// File: rtl/fft_magnitude_seq_pkg.sv
// Shared widths and FSM state encoding for the FFT magnitude block.
// Package name ap_parameters is kept for compatibility with the rest of the
// audio pipeline, which imports it under that name.
package ap_parameters;

    localparam int FFT_DATA_WIDTH = 16;
    localparam int MEL_DATA_WIDTH = 32;

    // Plain vector encoding so older tools and waveform scripts can match on values.
    typedef logic [1:0] mag_state_t;

    localparam mag_state_t ST_IDLE   = 2'd0;
    localparam mag_state_t ST_SQUARE = 2'd1;
    localparam mag_state_t ST_ROOT   = 2'd2;
    localparam mag_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/fft_magnitude_seq_isqrt_serial.sv
// Bit-serial restoring integer square root.
// A start pulse loads a 2*IN_W-bit radicand; exactly IN_W cycles later the
// floor square root is complete. 'done' is high during the cycle whose rising
// edge performs the final step, and 'root' then shows the finished result.
module isqrt_serial #(
    parameter int IN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*IN_W-1:0]    radicand,
    output logic                 busy,
    output logic                 done,
    output logic [IN_W-1:0]      root
);

    localparam int REM_W = IN_W + 2;
    localparam int CNT_W = $clog2(IN_W + 1);

    logic [2*IN_W-1:0] rad_reg;
    logic [REM_W-1:0]  rem_reg;
    logic [IN_W-1:0]   root_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;

    logic [REM_W-1:0]  rem_shift;
    logic [REM_W-1:0]  trial;
    logic              ge;
    logic [REM_W-1:0]  rem_next;
    logic [IN_W-1:0]   root_next;

    // One restoring step: bring down the next two radicand bits and try 4*root+1.
    always_comb begin
        rem_shift = (rem_reg << 2) | REM_W'(rad_reg[2*IN_W-1 -: 2]);
        trial     = (REM_W'(root_reg) << 2) | REM_W'(1);
        ge        = (rem_shift >= trial);
        rem_next  = ge ? (rem_shift - trial) : rem_shift;
        root_next = (root_reg << 1) | IN_W'(ge);
    end

    // Iteration state: load on start, then consume two radicand bits per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_reg  <= '0;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            rad_reg  <= radicand;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= CNT_W'(IN_W);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            rad_reg  <= rad_reg << 2;
            rem_reg  <= rem_next;
            root_reg <= root_next;
            cnt_reg  <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy = busy_reg;
    assign done = busy_reg && (cnt_reg == CNT_W'(1));
    assign root = root_next;

endmodule

// File: rtl/fft_magnitude_seq.sv
// Sequential FFT bin magnitude: floor(sqrt(re^2 + im^2)) with a fixed
// IN_W+2 cycle latency and a valid/ready handshake on both sides.
// Optional feature macro MAG_POWER_MODE_EN adds a power_mode input that
// returns re^2 + im^2 (saturated to OUT_W) after 2 cycles instead.
module fft_magnitude_seq
    import ap_parameters::*;
#(
    parameter int IN_W  = FFT_DATA_WIDTH,
    parameter int OUT_W = MEL_DATA_WIDTH,
    parameter int IDX_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   real_part,
    input  logic [IN_W-1:0]   imag_part,
    input  logic [IDX_W-1:0]  in_idx,
`ifdef MAG_POWER_MODE_EN
    input  logic              power_mode,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  magnitude,
    output logic [IDX_W-1:0]  out_idx
);

    generate
        if (OUT_W < IN_W) begin : g_bad_width
            $error("fft_magnitude_seq: OUT_W must be >= IN_W");
        end
    endgenerate

    mag_state_t          state_reg;
    logic [IN_W-1:0]     re_reg;
    logic [IN_W-1:0]     im_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [OUT_W-1:0]    mag_reg;
    logic                power_sel;

    logic                take;
    logic                sq_start;
    logic                sq_busy;
    logic                sq_done;
    logic [IN_W-1:0]     sq_root;

    logic signed [2*IN_W-1:0] re_ext;
    logic signed [2*IN_W-1:0] im_ext;
    logic signed [2*IN_W-1:0] re_sq;
    logic signed [2*IN_W-1:0] im_sq;
    logic [2*IN_W-1:0]        sum;

    // Handshake: accept when idle, or when the held result leaves this cycle.
    always_comb begin
        in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
        out_valid = (state_reg == ST_DONE);
        take      = in_valid && in_ready;
    end

    // Sum of squares; each square is non-negative and the sum peaks at
    // 2^(2*IN_W-1), so the unsigned 2*IN_W-bit sum never overflows.
    always_comb begin
        re_ext = {{IN_W{re_reg[IN_W-1]}}, re_reg};
        im_ext = {{IN_W{im_reg[IN_W-1]}}, im_reg};
        re_sq  = re_ext * re_ext;
        im_sq  = im_ext * im_ext;
        sum    = $unsigned(re_sq) + $unsigned(im_sq);
    end

`ifdef MAG_POWER_MODE_EN
    logic                pm_reg;
    logic [OUT_W-1:0]    pow_val;

    assign power_sel = pm_reg;

    generate
        if (OUT_W >= 2*IN_W) begin : g_pow_wide
            assign pow_val = OUT_W'(sum);
        end else begin : g_pow_sat
            assign pow_val = (|sum[2*IN_W-1:OUT_W]) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
        end
    endgenerate

    // Mode bit travels with the sample it was presented alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_reg <= 1'b0;
        end else if (take) begin
            pm_reg <= power_mode;
        end
    end
`else
    assign power_sel = 1'b0;
`endif

    assign sq_start = (state_reg == ST_SQUARE) && !power_sel;

    isqrt_serial #(
        .IN_W(IN_W)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand (sum),
        .busy     (sq_busy),
        .done     (sq_done),
        .root     (sq_root)
    );

    // Operand and tag capture; only happens on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_reg  <= '0;
            im_reg  <= '0;
            idx_reg <= '0;
        end else if (take) begin
            re_reg  <= real_part;
            im_reg  <= imag_part;
            idx_reg <= in_idx;
        end
    end

    // Control FSM and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            mag_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (take) begin
                        state_reg <= ST_SQUARE;
                    end
                end
                ST_SQUARE: begin
`ifdef MAG_POWER_MODE_EN
                    if (pm_reg) begin
                        mag_reg   <= pow_val;
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg <= ST_ROOT;
                    end
`else
                    state_reg <= ST_ROOT;
`endif
                end
                ST_ROOT: begin
                    // The root is final on the edge that completes the last step.
                    if (sq_busy && sq_done) begin
                        mag_reg   <= OUT_W'(sq_root);
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= in_valid ? ST_SQUARE : ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign magnitude = mag_reg;
    assign out_idx   = idx_reg;

endmodule

// File: tb/tb_fft_magnitude_seq.sv
// Self-checking bench for fft_magnitude_seq (IN_W=16, OUT_W=32, IDX_W=9).
// Define MAG_POWER_MODE_EN to also exercise the power_mode path.
module tb_fft_magnitude_seq;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int IDX_W = 9;
    localparam int MAG_LAT = IN_W + 2;
    localparam int POW_LAT = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   real_part;
    logic [IN_W-1:0]   imag_part;
    logic [IDX_W-1:0]  in_idx;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  magnitude;
    logic [IDX_W-1:0]  out_idx;
`ifdef MAG_POWER_MODE_EN
    logic              power_mode;
`endif

    fft_magnitude_seq #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .real_part  (real_part),
        .imag_part  (imag_part),
        .in_idx     (in_idx),
`ifdef MAG_POWER_MODE_EN
        .power_mode (power_mode),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .magnitude  (magnitude),
        .out_idx    (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint mag;
        int     idx;
        int     t_in;
        int     lat;
    } exp_t;

    exp_t exp_q[$];

    int checks_cnt = 0;
    int errors_cnt = 0;
    int cyc = 0;
    int txn_cnt = 0;
    bit head_seen = 0;

    // Pending input slot and stimulus knobs
    bit                cur_pend = 0;
    int                cur_re = 0;
    int                cur_im = 0;
    int                cur_idx = 0;
    bit                cur_pm = 0;
    longint            cur_exp = -1;
    bit                iv_rand = 0;
    bit                or_rand = 0;
    bit                or_fixed = 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: exact floor(sqrt(re^2+im^2)), or the saturated power.
    function automatic longint ref_result(input int re, input int im, input bit pm);
        longint s;
        longint r;
        longint max_out;
        s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        if (pm) begin
            max_out = (longint'(1) << OUT_W) - 1;
            return (s > max_out) ? max_out : s;
        end
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, observe 1 ns later,
    // then let the rising edge happen.
    task automatic step();
        exp_t e;
        in_valid  = cur_pend && (iv_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        real_part = IN_W'(cur_re);
        imag_part = IN_W'(cur_im);
        in_idx    = IDX_W'(cur_idx);
        out_ready = or_rand ? ($urandom_range(0, 3) != 0) : or_fixed;
`ifdef MAG_POWER_MODE_EN
        power_mode = cur_pm;
`endif
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                if (!head_seen) begin
                    check("latency", cyc - exp_q[0].t_in, exp_q[0].lat);
                    head_seen = 1;
                end
                check("magnitude", magnitude, exp_q[0].mag);
                check("out_idx", out_idx, exp_q[0].idx);
                check("in_ready_in_done", in_ready, out_ready);
                if (out_ready) begin
                    $display("txn %0d: idx=%0d magnitude=%0d expected=%0d cycle=%0d",
                             txn_cnt, out_idx, magnitude, exp_q[0].mag, cyc);
                    txn_cnt++;
                    void'(exp_q.pop_front());
                    head_seen = 0;
                end
            end
        end else begin
            check("in_ready_not_done", in_ready, (exp_q.size() == 0) ? 1 : 0);
        end
        if (in_valid && in_ready) begin
            e.mag  = (cur_exp >= 0) ? cur_exp : ref_result(cur_re, cur_im, cur_pm);
            e.idx  = cur_idx;
            e.t_in = cyc;
            e.lat  = cur_pm ? POW_LAT : MAG_LAT;
            exp_q.push_back(e);
            cur_pend = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input int re, input int im, input int idx, input bit pm, input longint expv);
        int n = 0;
        while (cur_pend && n < 400) begin
            step();
            n++;
        end
        if (cur_pend) check("send_timeout", 1, 0);
        cur_re   = re;
        cur_im   = im;
        cur_idx  = idx;
        cur_pm   = pm;
        cur_exp  = expv;
        cur_pend = 1;
    endtask

    task automatic drain();
        int n = 0;
        iv_rand  = 0;
        or_rand  = 0;
        or_fixed = 1;
        while ((cur_pend || exp_q.size() != 0) && n < 400) begin
            step();
            n++;
        end
        if (cur_pend || exp_q.size() != 0) check("drain_timeout", 1, 0);
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 7))
            0:       return -32768;
            1:       return 32767;
            2:       return int'($urandom_range(0, 15)) - 8;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    initial begin
        int n;
        bit pm_r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        real_part = '0;
        imag_part = '0;
        in_idx    = '0;
        out_ready = 1'b0;
`ifdef MAG_POWER_MODE_EN
        power_mode = 1'b0;
`endif
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_magnitude", magnitude, 0);
        check("reset_out_idx", out_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        @(negedge clk);

        // Directed values with known answers
        send(3, 4, 9'h1A5, 0, 5);               drain();
        send(-32768, -32768, 17, 0, 46340);     drain();
        send(0, 0, 18, 0, 0);                   drain();
        send(1, 1, 19, 0, 1);                   drain();
        send(0, -7, 20, 0, 7);                  drain();

        // Back-to-back stream: next sample accepted in the DONE cycle
        for (int i = 0; i < 6; i++) send(rand_sample(), rand_sample(), 100 + i, 0, -1);
        drain();

        // Output stall for 10 cycles with a second sample waiting
        or_fixed = 0;
        send(300, -400, 200, 0, 500);
        send(-5, 12, 201, 0, 13);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) check("stall_wait_timeout", 1, 0);
        repeat (10) step();
        drain();

        // Reset in the middle of ROOT
        send(1000, 2000, 300, 0, -1);
        repeat (8) step();
        rst = 1'b1;
        #1;
        check("midroot_rst_out_valid", out_valid, 0);
        check("midroot_rst_magnitude", magnitude, 0);
        check("midroot_rst_out_idx", out_idx, 0);
        exp_q.delete();
        head_seen = 0;
        cur_pend  = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        repeat (25) step();
        send(-123, 456, 301, 0, -1);
        drain();

`ifdef MAG_POWER_MODE_EN
        send(3, 4, 302, 1, 25);
        drain();
`endif

        // Randomised traffic with random in_valid gaps and output back-pressure
        for (int i = 0; i < 40; i++) begin
            pm_r = 0;
`ifdef MAG_POWER_MODE_EN
            pm_r = $urandom_range(0, 1) != 0;
`endif
            iv_rand = 1;
            or_rand = 1;
            send(rand_sample(), rand_sample(), int'($urandom_range(0, 511)), pm_r, -1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
